// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam logic [MDU_WIDTH-1:0] MIN_INT = {1'b1, {(MDU_WIDTH-1){1'b0}}};
  localparam logic [MDU_WIDTH-1:0] NEG_ONE = {MDU_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input mdu_op_e op);
    return op[2] & ~op[0];
  endfunction

  function automatic logic is_rem_op(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned restoring divider datapath; one quotient bit per step.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot_nxt,
  output logic [WIDTH-1:0] o_rem_nxt
);

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // Outputs are the post-step values so the final step's result is usable the same cycle.
  assign w_shift    = {r_prem, r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_fits     = ~w_diff[WIDTH];
  assign o_quot_nxt = {r_quot[WIDTH-2:0], w_fits};
  assign o_rem_nxt  = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  // Divider state: load operands or advance one restoring iteration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dvd  <= {WIDTH{1'b0}};
      r_dvs  <= {WIDTH{1'b0}};
      r_quot <= {WIDTH{1'b0}};
      r_prem <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_dvd  <= i_dividend;
      r_dvs  <= i_divisor;
      r_quot <= {WIDTH{1'b0}};
      r_prem <= {WIDTH{1'b0}};
    end else if (i_step) begin
      r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
      r_quot <= o_quot_nxt;
      r_prem <= o_rem_nxt;
    end
  end

endmodule

// File: rtl/mdu_controller.sv
// RV32M sequencer: one-pass multiply, WIDTH-step restoring divide, stall and
// single-cycle result pulse for the execute stage.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_e_i,
  input  logic [2:0]       funct3_e_i,
  input  logic [WIDTH-1:0] src_a_e_i,
  input  logic [WIDTH-1:0] src_b_e_i,
  input  logic             flush_e_i,
  output logic             mdu_stall_o,
  output logic [WIDTH-1:0] mdu_result_o,
  output logic             mdu_valid_o,
  output logic             mdu_busy_o
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e         r_state, w_next;
  mdu_op_e            r_op, w_op;
  logic [WIDTH-1:0]   r_a, r_b, r_result;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               w_cap, w_load, w_step, w_res_load;
  logic [WIDTH-1:0]   w_res_nxt;
  logic               w_sgn_in, w_div0, w_ovf;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_special;
  logic [WIDTH-1:0]   w_quot_nxt, w_rem_nxt, w_quot_fix, w_rem_fix;
  logic               w_neg_q, w_neg_r;
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;

  assign w_op     = mdu_op_e'(funct3_e_i);
  assign w_sgn_in = is_signed_div(w_op);
  assign w_div0   = (src_b_e_i == {WIDTH{1'b0}});
  assign w_ovf    = w_sgn_in & (src_a_e_i == MIN_INT) & (src_b_e_i == NEG_ONE);
  assign w_mag_a  = (w_sgn_in & src_a_e_i[WIDTH-1]) ? -src_a_e_i : src_a_e_i;
  assign w_mag_b  = (w_sgn_in & src_b_e_i[WIDTH-1]) ? -src_b_e_i : src_b_e_i;
  assign w_special = w_ovf ? (is_rem_op(w_op) ? {WIDTH{1'b0}} : MIN_INT)
                           : (is_rem_op(w_op) ? src_a_e_i : NEG_ONE);

  // Multiply operands extended to full product width; sign taken only where the op is signed.
  assign w_mul_a = {{WIDTH{((r_op == OP_MULH) || (r_op == OP_MULHSU)) & r_a[WIDTH-1]}}, r_a};
  assign w_mul_b = {{WIDTH{(r_op == OP_MULH) & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_neg_q    = is_signed_div(r_op) & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r    = is_signed_div(r_op) & r_a[WIDTH-1];
  assign w_quot_fix = w_neg_q ? -w_quot_nxt : w_quot_nxt;
  assign w_rem_fix  = w_neg_r ? -w_rem_nxt : w_rem_nxt;

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .i_clk      (clk_i),
    .i_rst_n    (reset_n_i),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  // Next-state and datapath control; flush overrides everything.
  always_comb begin
    w_next     = r_state;
    w_cap      = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_res_load = 1'b0;
    w_res_nxt  = r_result;
    if (flush_e_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_e_i) begin
            w_cap = 1'b1;
            if (!is_div_op(w_op)) begin
              w_next = ST_MUL;
            end else if (w_div0 || w_ovf) begin
              w_res_load = 1'b1;
              w_res_nxt  = w_special;
              w_next     = ST_DONE;
            end else begin
              w_load = 1'b1;
              w_next = ST_DIV;
            end
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_MUL: begin
          w_res_load = 1'b1;
          w_res_nxt  = (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
          w_next     = ST_DONE;
        end
        ST_DIV: begin
          w_step = 1'b1;
          if (r_count == CNT_W'(WIDTH-1)) begin
            w_res_load = 1'b1;
            w_res_nxt  = is_rem_op(r_op) ? w_rem_fix : w_quot_fix;
            w_next     = ST_DONE;
          end else begin
            w_next = ST_DIV;
          end
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Control and operand registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_op     <= OP_MUL;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      if (w_cap) begin
        r_op <= w_op;
        r_a  <= src_a_e_i;
        r_b  <= src_b_e_i;
      end
      if (w_res_load) begin
        r_result <= w_res_nxt;
      end
      if (w_load) begin
        r_count <= {CNT_W{1'b0}};
      end else if (w_step) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign mdu_stall_o  = ~flush_e_i & (((r_state == ST_IDLE) & start_e_i) |
                                      (r_state == ST_MUL) | (r_state == ST_DIV));
  assign mdu_valid_o  = (r_state == ST_DONE) & ~flush_e_i;
  assign mdu_busy_o   = r_busy;
  assign mdu_result_o = r_result;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller with hand-computed expected results and cycle counts.
module tb_mdu_controller;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_e_i;
  logic [2:0]  funct3_e_i;
  logic [31:0] src_a_e_i;
  logic [31:0] src_b_e_i;
  logic        flush_e_i;
  logic        mdu_stall_o;
  logic [31:0] mdu_result_o;
  logic        mdu_valid_o;
  logic        mdu_busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mdu_controller dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .start_e_i    (start_e_i),
    .funct3_e_i   (funct3_e_i),
    .src_a_e_i    (src_a_e_i),
    .src_b_e_i    (src_b_e_i),
    .flush_e_i    (flush_e_i),
    .mdu_stall_o  (mdu_stall_o),
    .mdu_result_o (mdu_result_o),
    .mdu_valid_o  (mdu_valid_o),
    .mdu_busy_o   (mdu_busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Holds one instruction in execute until its valid pulse (or a 100-cycle bound).
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
    int cyc;
    int stalls;
    bit seen;
    cyc = 0;
    stalls = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk_i);
      start_e_i  = 1'b1;
      flush_e_i  = 1'b0;
      funct3_e_i = f3;
      src_a_e_i  = a;
      src_b_e_i  = b;
      #1;
      cyc++;
      if (cyc == 1) check_eq({tag, " busy@accept"}, 32'(mdu_busy_o), 32'd0);
      if (mdu_valid_o) begin
        seen = 1'b1;
        check_eq({tag, " result"}, mdu_result_o, exp);
        check_eq({tag, " stall@done"}, 32'(mdu_stall_o), 32'd0);
        check_eq({tag, " busy@done"}, 32'(mdu_busy_o), 32'd1);
      end else if (mdu_stall_o) begin
        stalls++;
      end
    end
    check_eq({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, " stall cycles"}, 32'(stalls), 32'(exp_cyc - 1));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk_i);
    start_e_i = 1'b0;
    flush_e_i = 1'b0;
    #1;
    check_eq({tag, " valid"}, 32'(mdu_valid_o), 32'd0);
    check_eq({tag, " busy"}, 32'(mdu_busy_o), 32'd0);
    check_eq({tag, " stall"}, 32'(mdu_stall_o), 32'd0);
  endtask

  initial begin
    int stalls;
    bit vseen;
    reset_n_i  = 1'b0;
    start_e_i  = 1'b0;
    flush_e_i  = 1'b0;
    funct3_e_i = 3'b000;
    src_a_e_i  = 32'd0;
    src_b_e_i  = 32'd0;
    #12;
    check_eq("reset stall", 32'(mdu_stall_o), 32'd0);
    check_eq("reset valid", 32'(mdu_valid_o), 32'd0);
    check_eq("reset busy", 32'(mdu_busy_o), 32'd0);
    check_eq("reset result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    run_op("MULH -2*3",     3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 3);
    run_op("MUL -2*3",      3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 3);
    run_op("MULHSU -2*max", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
    run_op("MULH -2*-1",    3'b001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 3);
    run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    run_op("REM -7/2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    run_op("DIV 7/-2",      3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("DIVU 100/7",    3'b101, 32'd100,       32'd7,         32'd14,        34);
    run_op("DIVU 5/0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
    run_op("REMU 5/0",      3'b111, 32'd5,         32'd0,         32'd5,         2);
    run_op("REM -7/0",      3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2);
    run_op("DIV ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("REM ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
    idle_check("after specials");

    // Flush a divide while its iteration count is 10.
    @(negedge clk_i);
    start_e_i  = 1'b1;
    funct3_e_i = 3'b100;
    src_a_e_i  = 32'd1000;
    src_b_e_i  = 32'd3;
    #1;
    check_eq("flush accept stall", 32'(mdu_stall_o), 32'd1);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      if (mdu_stall_o) stalls++;
    end
    check_eq("flush pre stalls", 32'(stalls), 32'd10);
    @(negedge clk_i);
    flush_e_i = 1'b1;
    #1;
    check_eq("flush stall drop", 32'(mdu_stall_o), 32'd0);
    check_eq("flush valid", 32'(mdu_valid_o), 32'd0);
    @(negedge clk_i);
    flush_e_i = 1'b0;
    start_e_i = 1'b0;
    #1;
    check_eq("post flush busy", 32'(mdu_busy_o), 32'd0);
    vseen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      #1;
      if (mdu_valid_o) vseen = 1'b1;
    end
    check_eq("post flush no valid", 32'(vseen), 32'd0);
    run_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);

    // Reset in the middle of a divide.
    @(negedge clk_i);
    start_e_i  = 1'b1;
    funct3_e_i = 3'b101;
    src_a_e_i  = 32'd100;
    src_b_e_i  = 32'd7;
    repeat (5) @(negedge clk_i);
    start_e_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_eq("midrst stall", 32'(mdu_stall_o), 32'd0);
    check_eq("midrst valid", 32'(mdu_valid_o), 32'd0);
    check_eq("midrst busy", 32'(mdu_busy_o), 32'd0);
    check_eq("midrst result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    run_op("DIVU 10/3", 3'b101, 32'd10, 32'd3, 32'd3, 34);

    // Back-to-back ops with no gap cycle.
    run_op("b2b MUL 6*7",   3'b000, 32'd6,  32'd7, 32'd42, 3);
    run_op("b2b REMU 10/3", 3'b111, 32'd10, 32'd3, 32'd1,  34);
    idle_check("final idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
